// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM state encoding, frame bit constants
// and the watchdog cycle-count helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam int   FRAME_BITS = 11;
   localparam int   DATA_BITS  = 8;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic PARITY_ODD = 1'b1;

   function automatic int timeout_cycles(input int sys_clk_hz, input int timeout_us);
      return (sys_clk_hz / 1_000_000) * timeout_us;
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Small first-word-fall-through FIFO: head is always the oldest entry,
// occupancy is tracked in its own counter next to the wrapping pointers.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered lines, bit-level
// frame FSM with watchdog, sticky error flags and a FWFT receive FIFO.
import ps2_pkg::*;

module ps2_rx_fifo #(
   parameter int SYS_CLK_HZ = 25_000_000,
   parameter int TIMEOUT_US = 120,
   parameter int FILTER_LEN = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   input  logic                          err_clear,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          irq,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_timeout,
   output logic                          overflow
);

   localparam int TIMEOUT_CYCLES = timeout_cycles(SYS_CLK_HZ, TIMEOUT_US);
   localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0] line_raw;
   logic [1:0] line_filt;
   assign line_raw = {ps2_data, ps2_clk};

   // Index 0 is the clock line, index 1 the data line; both see identical delay.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic       meta_reg;
         logic       sync_reg;
         logic       filt_reg;
         logic [3:0] cnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
               filt_reg <= 1'b1;
               cnt_reg  <= '0;
            end else begin
               meta_reg <= line_raw[gi];
               sync_reg <= meta_reg;
               if (sync_reg == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == 4'(FILTER_LEN - 1)) begin
                  filt_reg <= sync_reg;
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign line_filt[gi] = filt_reg;
      end
   endgenerate

   logic clk_f;
   logic data_f;
   logic clk_prev_reg;
   logic fall;

   assign clk_f  = line_filt[0];
   assign data_f = line_filt[1];
   assign fall   = clk_prev_reg & ~clk_f;

   ps2_state_t state_reg, state_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic            parity_reg, parity_next;
   logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
   logic            push_req;
   logic            set_parity;
   logic            set_frame;
   logic            set_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_prev_reg <= 1'b1;
         state_reg    <= ST_IDLE;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         wd_cnt_reg   <= '0;
      end else begin
         clk_prev_reg <= clk_f;
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         parity_reg   <= parity_next;
         wd_cnt_reg   <= wd_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      parity_next  = parity_reg;
      wd_cnt_next  = '0;
      push_req     = 1'b0;
      set_parity   = 1'b0;
      set_frame    = 1'b0;
      set_timeout  = 1'b0;

      if (state_reg != ST_IDLE && wd_cnt_reg == WD_W'(TIMEOUT_CYCLES)) begin
         set_timeout  = 1'b1;
         state_next   = ST_IDLE;
         bit_cnt_next = '0;
         shift_next   = '0;
      end else begin
         if (state_reg != ST_IDLE && !fall) wd_cnt_next = wd_cnt_reg + 1'b1;
         if (fall) begin
            case (state_reg)
               ST_IDLE: begin
                  if (data_f == START_BIT) begin
                     state_next   = ST_DATA;
                     bit_cnt_next = '0;
                  end
               end
               ST_DATA: begin
                  shift_next   = {data_f, shift_reg[7:1]};
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 3'(DATA_BITS - 1)) state_next = ST_PARITY;
               end
               ST_PARITY: begin
                  parity_next = data_f;
                  state_next  = ST_STOP;
               end
               ST_STOP: begin
                  state_next = ST_IDLE;
                  if ((^shift_reg ^ parity_reg) != PARITY_ODD) set_parity = 1'b1;
                  else if (data_f != STOP_BIT)                 set_frame  = 1'b1;
                  else                                         push_req   = 1'b1;
               end
               default: state_next = ST_IDLE;
            endcase
         end
      end
   end

   logic [7:0] fifo_head;
   logic       fifo_full;
   logic       fifo_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_req),
      .pop     (rd_en),
      .wr_data (shift_reg),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   logic err_parity_reg, err_frame_reg, err_timeout_reg, overflow_reg;
   logic set_overflow;

   assign set_overflow = push_req & fifo_full & ~rd_en;

   // A set in the same cycle as err_clear keeps the flag high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_parity_reg  <= 1'b0;
         err_frame_reg   <= 1'b0;
         err_timeout_reg <= 1'b0;
         overflow_reg    <= 1'b0;
      end else begin
         err_parity_reg  <= set_parity   | (err_parity_reg  & ~err_clear);
         err_frame_reg   <= set_frame    | (err_frame_reg   & ~err_clear);
         err_timeout_reg <= set_timeout  | (err_timeout_reg & ~err_clear);
         overflow_reg    <= set_overflow | (overflow_reg    & ~err_clear);
      end
   end

   assign empty       = fifo_empty;
   assign rd_data     = fifo_empty ? 8'h00 : fifo_head;
   assign err_parity  = err_parity_reg;
   assign err_frame   = err_frame_reg;
   assign err_timeout = err_timeout_reg;
   assign overflow    = overflow_reg;
   assign irq         = ~fifo_empty | err_parity_reg | err_frame_reg
                        | err_timeout_reg | overflow_reg;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It is the successor to the single-byte PS/2 decoder. Adds:
- input synchronisation and a glitch filter
- an explicit bit-level frame FSM with a per-bit watchdog timeout
- classified, sticky error flags
- a first-word-fall-through receive FIFO, so bursts of scan codes (e.g. E0 F0 xx break sequences) are not lost while the CPU-side bus logic is busy

Parameters:
- SYS_CLK_HZ, 25_000_000: system clock frequency; used to derive the timeout.
- TIMEOUT_US, 120: maximum gap between ps2_clk falling edges inside a frame before the frame is aborted.
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered line changes; range 1..15.
- FIFO_DEPTH, 8: receive FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_data  in  1  raw PS/2 data line, asynchronous
- rd_en  in  1  pop head of FIFO; ignored when empty
- err_clear  in  1  single-cycle pulse; clears all sticky error flags
- rd_data  out  8  FIFO head (first-word fall-through); 0 when empty
- empty  out  1  FIFO empty
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- irq  out  1  level: !empty or any sticky error set
- err_parity  out  1  sticky: frame dropped for bad odd parity
- err_frame  out  1  sticky: frame dropped for stop bit == 0
- err_timeout  out  1  sticky: frame aborted by watchdog
- overflow  out  1  sticky: good frame dropped because FIFO full

Behaviour:
- One clock domain. rst_n is asynchronous assert, clocked deassert, and resets every register.
- Reset values:
  - synchroniser and filter outputs 1
  - FSM IDLE, FIFO empty, count 0, rd_data 0, irq 0
  - all error flags 0
- Synchronisation: 2-flop synchroniser on each of ps2_clk and ps2_data.
- Glitch filter:
  - A per-line counter increments while the synchronised sample differs from the filtered value, and resets to 0 when they match.
  - On reaching FILTER_LEN, the filtered value flips.
- Edge detect: a fall event is filtered clk 1->0, registered. The filtered data is sampled in the same cycle as the fall event.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data==0 (start bit), go to DATA with bit_cnt=0. On fall with data==1, stay in IDLE; no error is raised.
  - DATA: on fall, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, exactly one outcome, then return to IDLE:
    - If the XOR of the 8 data bits and the parity bit is 0 (even, i.e. odd parity failed), set err_parity; drop the frame.
    - Else if data==0, set err_frame; drop the frame.
    - Else issue a push request.
- Watchdog:
  - TIMEOUT_CYCLES = SYS_CLK_HZ/1_000_000*TIMEOUT_US; counter width $clog2(TIMEOUT_CYCLES+1).
  - Counts while state != IDLE and is cleared on every fall event.
  - At TIMEOUT_CYCLES: set err_timeout, go to IDLE, discard the partial byte.
  - The counter is held at 0 in IDLE.
- Push latency: the byte appears at rd_data, with empty=0, on the cycle after the STOP fall event. End to end, this is at most 2+FILTER_LEN+2 clk cycles after the raw stop-bit falling edge.
- FIFO:
  - Circular buffer; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - count is tracked separately.
  - push & full & !rd_en: byte dropped, overflow set, count unchanged.
  - push & full & rd_en: both occur, count stays FIFO_DEPTH, no overflow.
  - push & empty & rd_en: rd_en ignored (empty); push occurs, count becomes 1.
  - rd_en while empty: no effect.
- Error flags:
  - A set event in the same cycle as err_clear wins (the flag stays 1).
  - err_clear does not affect the FIFO.
- irq is combinational from registered state; there is no extra latency.
- Reset mid-frame: partial frame lost, no flags set after release. The first frame after release decodes normally.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE=0, DATA=1, PARITY=2, STOP=3)
  - PS2 frame constants: 11 bits, start 0, stop 1, odd parity
  - helper function for the timeout cycle count
- One natural sub-module: sync_fifo (parameters WIDTH=8, DEPTH; push/pop/full/empty/count/head). It is reused later by the PS/2 transmit path.
- Synchroniser plus filter stays inline; it is replicated twice in a generate loop.

Test Plan:
- Valid frame 0x1C (parity 0, stop 1) at a 10 kHz PS/2 clock -> within 2+FILTER_LEN+2 clk of the stop edge: rd_data=0x1C, empty=0, count=1, irq=1, no error flags. Pulse rd_en -> empty=1, rd_data=0, irq=0.
- Burst E0 F0 1C back-to-back, no reads -> count=3. Three pops return E0, F0, 1C in order.
- Frame 0x1C with parity bit 1 -> FIFO unchanged, err_parity=1, irq=1. err_clear -> err_parity=0, irq=0. Next good frame 0x29 is received.
- Stop bit 0 -> err_frame=1, nothing pushed. Second case: stop ps2_clk high after the 4th data bit for longer than 120 us -> err_timeout=1, FSM in IDLE, following frame 0x5A decodes correctly.
- FIFO_DEPTH+1 good frames 0x01.. with no reads -> count=FIFO_DEPTH, overflow=1, last byte lost. With rd_en asserted on the cycle of the 9th push -> overflow stays 0.
- Glitches on ps2_clk of FILTER_LEN-1 cycles low mid-frame -> no extra bit shifted, byte correct. Separately, assert rst_n low mid-frame -> all outputs at reset values, next frame is good.
